// File: rtl/spi_master.sv
// SPI bus initiator: shifts one WORDSIZE-bit word out on MOSI while capturing MISO,
// framing each transfer with SS lead/trail time and an inter-word gap.
module spi_master #(
    parameter int WORDSIZE  = 8,
    parameter int CPOL      = 0,
    parameter int CPHA      = 0,
    parameter int MSB_FIRST = 1,
    parameter int SCK_DIV   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [WORDSIZE-1:0] tx_data,
    output logic                busy,
    output logic [WORDSIZE-1:0] rx_data,
    output logic                rx_valid,
    output logic                sck,
    output logic                ss,
    output logic                mosi,
    input  logic                miso
);

    localparam int HW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    // Wide enough to hold the final edge number 2*WORDSIZE (64 when WORDSIZE = 32).
    localparam int EW = $clog2(2 * WORDSIZE + 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(SCK_DIV - 1);
    localparam logic [EW-1:0] EDGE_LAST = EW'(2 * WORDSIZE);
    localparam logic          SCK_IDLE  = (CPOL != 0);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        XFER,
        TRAIL,
        GAP
    } state_t;

    state_t                state_q;
    logic [HW-1:0]         half_q;
    logic [EW-1:0]         edge_q;
    logic [WORDSIZE-1:0]   tx_q;
    logic [WORDSIZE-1:0]   rx_q;
    logic [WORDSIZE-1:0]   rx_data_q;
    logic                  sck_q;
    logic                  ss_q;
    logic                  mosi_q;
    logic                  busy_q;
    logic                  rx_valid_q;

    logic                  half_end;
    logic [EW-1:0]         edge_d;
    logic                  sample_edge;
    logic                  setup_edge;
    logic                  tx_head;
    logic [WORDSIZE-1:0]   tx_shift_d;
    logic [WORDSIZE-1:0]   rx_shift_d;
    logic                  first_bit;
    logic [WORDSIZE-1:0]   load_shift;

    always_comb begin
        half_end    = (half_q == HALF_LAST);
        edge_d      = edge_q + 1'b1;
        // Odd edges are leading edges; CPHA selects which parity samples.
        sample_edge = (CPHA == 0) ? edge_d[0] : ~edge_d[0];
        setup_edge  = ~sample_edge & ~((CPHA == 0) && (edge_d == EDGE_LAST));
        tx_head     = (MSB_FIRST != 0) ? tx_q[WORDSIZE-1] : tx_q[0];
        tx_shift_d  = (MSB_FIRST != 0) ? (tx_q << 1) : (tx_q >> 1);
        rx_shift_d  = (MSB_FIRST != 0) ? ((rx_q << 1) | WORDSIZE'(miso))
                                       : ((rx_q >> 1) | (WORDSIZE'(miso) << (WORDSIZE - 1)));
        first_bit   = (MSB_FIRST != 0) ? tx_data[WORDSIZE-1] : tx_data[0];
        load_shift  = (MSB_FIRST != 0) ? (tx_data << 1) : (tx_data >> 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            half_q     <= '0;
            edge_q     <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            rx_data_q  <= '0;
            sck_q      <= SCK_IDLE;
            ss_q       <= 1'b1;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    half_q <= '0;
                    if (start) begin
                        // CPHA=0 presents the first bit during LEAD, so it is consumed here.
                        tx_q    <= (CPHA == 0) ? load_shift : tx_data;
                        mosi_q  <= (CPHA == 0) ? first_bit : 1'b0;
                        rx_q    <= '0;
                        edge_q  <= '0;
                        ss_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= LEAD;
                    end
                end
                LEAD, XFER: begin
                    if (half_end) begin
                        half_q <= '0;
                        edge_q <= edge_d;
                        if (sample_edge) begin
                            rx_q <= rx_shift_d;
                        end
                        if (setup_edge) begin
                            mosi_q <= tx_head;
                            tx_q   <= tx_shift_d;
                        end
                        if (edge_d == EDGE_LAST) begin
                            sck_q   <= SCK_IDLE;
                            state_q <= TRAIL;
                        end else begin
                            sck_q   <= ~sck_q;
                            state_q <= XFER;
                        end
                    end else begin
                        half_q <= half_q + 1'b1;
                    end
                end
                TRAIL: begin
                    if (half_end) begin
                        half_q     <= '0;
                        ss_q       <= 1'b1;
                        mosi_q     <= 1'b0;
                        rx_data_q  <= rx_q;
                        rx_valid_q <= 1'b1;
                        state_q    <= GAP;
                    end else begin
                        half_q <= half_q + 1'b1;
                    end
                end
                GAP: begin
                    if (half_end) begin
                        half_q  <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        half_q <= half_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign sck      = sck_q;
    assign ss       = ss_q;
    assign mosi     = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Cycle-accurate check of spi_master in four configurations against a timing/bit-order
// model derived from edge positions (edge k at cycle 1 + k*H after accept).
module tb_spi_master;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        start_v [4];
    logic [31:0] tx_v    [4];
    logic        loop_v  [4];
    logic        drv_v   [4];
    logic [31:0] prev_rx [4];

    int WP [4];
    int CP [4];
    int HP [4];
    int MP [4];
    int DP [4];

    int n_cmp;
    int n_err;

    logic       sck0, ss0, mosi0, busy0, rxv0, miso0;
    logic [7:0] rx0;
    logic       sck1, ss1, mosi1, busy1, rxv1, miso1;
    logic [7:0] rx1;
    logic       sck2, ss2, mosi2, busy2, rxv2, miso2;
    logic [3:0] rx2;
    logic       sck3, ss3, mosi3, busy3, rxv3, miso3;
    logic [31:0] rx3;

    assign miso0 = loop_v[0] ? mosi0 : drv_v[0];
    assign miso1 = loop_v[1] ? mosi1 : drv_v[1];
    assign miso2 = loop_v[2] ? mosi2 : drv_v[2];
    assign miso3 = loop_v[3] ? mosi3 : drv_v[3];

    spi_master #(.WORDSIZE(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .SCK_DIV(2)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .tx_data(tx_v[0][7:0]),
        .busy(busy0), .rx_data(rx0), .rx_valid(rxv0), .sck(sck0), .ss(ss0),
        .mosi(mosi0), .miso(miso0));

    spi_master #(.WORDSIZE(8), .CPOL(1), .CPHA(1), .MSB_FIRST(0), .SCK_DIV(2)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .tx_data(tx_v[1][7:0]),
        .busy(busy1), .rx_data(rx1), .rx_valid(rxv1), .sck(sck1), .ss(ss1),
        .mosi(mosi1), .miso(miso1));

    spi_master #(.WORDSIZE(4), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .SCK_DIV(1)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .tx_data(tx_v[2][3:0]),
        .busy(busy2), .rx_data(rx2), .rx_valid(rxv2), .sck(sck2), .ss(ss2),
        .mosi(mosi2), .miso(miso2));

    spi_master #(.WORDSIZE(32), .CPOL(0), .CPHA(1), .MSB_FIRST(1), .SCK_DIV(3)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start_v[3]), .tx_data(tx_v[3]),
        .busy(busy3), .rx_data(rx3), .rx_valid(rxv3), .sck(sck3), .ss(ss3),
        .mosi(mosi3), .miso(miso3));

    typedef struct packed {
        logic        sck;
        logic        ss;
        logic        mosi;
        logic        busy;
        logic        rxv;
        logic [31:0] rx;
    } obs_t;

    function automatic obs_t get_obs(input int s);
        obs_t o;
        case (s)
            0:       o = {sck0, ss0, mosi0, busy0, rxv0, 24'b0, rx0};
            1:       o = {sck1, ss1, mosi1, busy1, rxv1, 24'b0, rx1};
            2:       o = {sck2, ss2, mosi2, busy2, rxv2, 28'b0, rx2};
            default: o = {sck3, ss3, mosi3, busy3, rxv3, rx3};
        endcase
        return o;
    endfunction

    function automatic logic bit_at(input logic [31:0] word, input int idx, input int w, input int msb);
        return (msb != 0) ? word[w-1-idx] : word[idx];
    endfunction

    // Bit on the line after c edges: CPHA=0 shows bit i from edge 2i, CPHA=1 from edge 2i+1.
    function automatic logic line_bit(input logic [31:0] word, input int c, input int w,
                                      input int cpha, input int msb);
        int idx;
        if (cpha == 0) begin
            idx = c / 2;
        end else begin
            if (c == 0) return 1'b0;
            idx = (c - 1) / 2;
        end
        if (idx > w - 1) idx = w - 1;
        return bit_at(word, idx, w, msb);
    endfunction

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic chk_reset_state(input int s, input string where);
        obs_t o;
        o = get_obs(s);
        chk($sformatf("%s u%0d sck", where, s), 32'(o.sck), 32'(CP[s]));
        chk($sformatf("%s u%0d ss", where, s), 32'(o.ss), 32'd1);
        chk($sformatf("%s u%0d mosi", where, s), 32'(o.mosi), 32'd0);
        chk($sformatf("%s u%0d busy", where, s), 32'(o.busy), 32'd0);
        chk($sformatf("%s u%0d rx_valid", where, s), 32'(o.rxv), 32'd0);
        chk($sformatf("%s u%0d rx_data", where, s), o.rx, 32'd0);
    endtask

    // Runs one full transfer on instance s, checking every output on every cycle.
    task automatic run_xfer(input int s, input logic [31:0] tx, input logic [31:0] sw,
                            input bit loop, input bit hold, input int poke_t);
        int w, h, c, t_valid, t_last;
        logic [31:0] mask, exp_rx;
        logic in_frame;
        obs_t o;
        w       = WP[s];
        h       = DP[s];
        mask    = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        exp_rx  = loop ? (tx & mask) : (sw & mask);
        t_valid = 1 + (2 * w + 1) * h;
        t_last  = 1 + (2 * w + 2) * h;
        loop_v[s] = loop;
        drv_v[s]  = 1'b0;
        o = get_obs(s);
        chk($sformatf("u%0d idle busy before start", s), 32'(o.busy), 32'd0);
        tx_v[s]    = tx;
        start_v[s] = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start_v[s] = 1'b0;
        for (int t = 1; t <= t_last; t++) begin
            c = (t - 1) / h;
            if (c > 2 * w) c = 2 * w;
            in_frame = (t < t_valid);
            o = get_obs(s);
            chk($sformatf("u%0d t%0d sck", s, t), 32'(o.sck), 32'(CP[s] ^ (c % 2)));
            chk($sformatf("u%0d t%0d ss", s, t), 32'(o.ss), 32'(!in_frame));
            chk($sformatf("u%0d t%0d mosi", s, t), 32'(o.mosi),
                32'(in_frame ? line_bit(tx, c, w, HP[s], MP[s]) : 1'b0));
            chk($sformatf("u%0d t%0d busy", s, t), 32'(o.busy), 32'(t < t_last));
            chk($sformatf("u%0d t%0d rx_valid", s, t), 32'(o.rxv), 32'(t == t_valid));
            chk($sformatf("u%0d t%0d rx_data", s, t), o.rx, (t >= t_valid) ? exp_rx : prev_rx[s]);
            drv_v[s] = in_frame ? line_bit(sw, c, w, HP[s], MP[s]) : 1'b0;
            if (t == poke_t) begin
                tx_v[s]    = 32'hFFFF_FFFF;
                start_v[s] = 1'b1;
            end else if (t == poke_t + 1) begin
                start_v[s] = 1'b0;
            end
            if (t < t_last) begin
                @(posedge clk);
                #1;
            end
        end
        prev_rx[s] = exp_rx;
        $display("u%0d transfer tx=%0h rx=%0h done", s, tx, exp_rx);
    endtask

    initial begin
        obs_t o;
        n_cmp = 0;
        n_err = 0;
        WP = '{8, 8, 4, 32};
        CP = '{0, 1, 0, 0};
        HP = '{0, 1, 0, 1};
        MP = '{1, 0, 1, 1};
        DP = '{2, 2, 1, 3};
        rst_n = 1'b0;
        for (int s = 0; s < 4; s++) begin
            start_v[s] = 1'b0;
            tx_v[s]    = 32'h0;
            loop_v[s]  = 1'b1;
            drv_v[s]   = 1'b0;
            prev_rx[s] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++) chk_reset_state(s, "reset");
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Mode 0 loopback, directed then random
        run_xfer(0, 32'hA5, 32'h0, 1'b1, 1'b0, -1);
        repeat (3) run_xfer(0, $urandom & 32'hFF, 32'h0, 1'b1, 1'b0, -1);

        // Mode 3 LSB-first against an external slave word
        run_xfer(1, 32'h3C, 32'h96, 1'b0, 1'b0, -1);
        repeat (2) run_xfer(1, $urandom, $urandom, 1'b0, 1'b0, -1);

        // start pulsed mid-transfer with 0xFF must be ignored
        run_xfer(0, 32'h66, 32'h0, 1'b1, 1'b0, 10);

        // Reset asserted when edge 7 is on the wire
        tx_v[0]    = 32'hC3;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        o = get_obs(0);
        chk("abort pre-reset sck", 32'(o.sck), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_state(0, "abort");
        #2 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            o = get_obs(0);
            chk($sformatf("abort quiet rx_valid %0d", i), 32'(o.rxv), 32'd0);
            chk($sformatf("abort quiet busy %0d", i), 32'(o.busy), 32'd0);
        end
        for (int s = 0; s < 4; s++) prev_rx[s] = 32'h0;
        run_xfer(0, 32'h5A, 32'h0, 1'b1, 1'b0, -1);

        // SCK_DIV = 1, W = 4, start held high: back-to-back words
        run_xfer(2, 32'h9, 32'h0, 1'b1, 1'b1, -1);
        run_xfer(2, 32'h6, 32'h0, 1'b1, 1'b0, -1);
        run_xfer(2, $urandom & 32'hF, 32'h0, 1'b1, 1'b1, -1);
        run_xfer(2, $urandom & 32'hF, 32'h0, 1'b1, 1'b0, -1);

        // W = 32, mode 1
        run_xfer(3, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b0, -1);
        run_xfer(3, $urandom, $urandom, 1'b0, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
